// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-side memory responder.
package dmem_responder_pkg;

    // Responder control states: nothing in flight, counting down, or answering.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_type;

    // One request as held in the skid buffer.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        fence;
        logic        spec;
    } dmem_req_type;

    // True when addr falls inside the RAM window starting at base.
    // The window spans 4 * 2^depth_log2 bytes and base is aligned to it.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int          depth_log2);
        logic [31:0] mask;
        mask = ~((32'd4 << depth_log2) - 32'd1);
        return (addr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/dmem_responder_ram.sv
// Single-port word RAM with byte write enables and a registered read port.
module dmem_ram #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clock,
    input  logic                  re,
    input  logic [3:0]            we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

    // Commit enabled byte lanes and capture the addressed word (pre-write
    // contents) on the same edge; contents are never cleared.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder: accepts request pulses, serves them from a
// local byte-enabled RAM and answers after a fixed latency, with a
// one-entry skid buffer for requests that arrive while busy.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_fence,
    input  logic        mem_spec,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        overflow
);

    // Countdown loaded on launch; LATENCY is limited to 1..4 so two bits suffice.
    localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

    dmem_state_type state, state_next;
    logic [1:0]     cnt, cnt_next;
    logic           skid_valid, skid_valid_next;
    dmem_req_type   skid, skid_next;
    logic           zero_q, zero_next;
    logic           overflow_q, overflow_next;

    dmem_req_type   new_req, launch_req;
    logic           launch;
    logic           launch_in_range;

    logic [3:0]            ram_we;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [31:0]           ram_rdata;

    // The instruction-side flag carries no meaning on the data side.
    logic unused_instr;
    assign unused_instr = mem_instr;

    // Package the incoming request pins so they can be parked or launched as one.
    always_comb begin
        new_req.addr  = mem_addr;
        new_req.wdata = mem_wdata;
        new_req.wstrb = mem_wstrb;
        new_req.fence = mem_fence;
        new_req.spec  = mem_spec;
    end

    // Next-state logic: launch decisions, countdown, skid fill/drain and drops.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        skid_valid_next = skid_valid;
        skid_next       = skid;
        zero_next       = zero_q;
        overflow_next   = overflow_q;
        launch          = 1'b0;
        launch_req      = new_req;

        case (state)
            IDLE: begin
                if (mem_valid) begin
                    launch = 1'b1;
                end
            end
            WAIT: begin
                if (cnt <= 2'd1) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 2'd1;
                end
                if (mem_valid) begin
                    if (!skid_valid) begin
                        skid_valid_next = 1'b1;
                        skid_next       = new_req;
                    end else begin
                        overflow_next = 1'b1;
                    end
                end
            end
            RESP: begin
                if (skid_valid) begin
                    launch     = 1'b1;
                    launch_req = skid;
                    if (mem_valid) begin
                        skid_next = new_req;
                    end else begin
                        skid_valid_next = 1'b0;
                    end
                end else if (mem_valid) begin
                    launch = 1'b1;
                end
                if (!launch) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        launch_in_range = in_window(launch_req.addr, BASE_ADDR, DEPTH_LOG2);

        if (launch) begin
            state_next = (LATENCY == 1) ? RESP : WAIT;
            cnt_next   = CNT_INIT;
            zero_next  = launch_req.fence || (launch_req.wstrb != 4'h0) || !launch_in_range;
        end
    end

    // RAM port driven by the launched request; fences, speculative stores and
    // out-of-window accesses never write.
    always_comb begin
        ram_idx = launch_req.addr[DEPTH_LOG2+1:2];
        ram_we  = 4'h0;
        if (launch && launch_in_range && !launch_req.fence && !launch_req.spec) begin
            ram_we = launch_req.wstrb;
        end
    end

    // Control state register with synchronous active-low reset; aborts any
    // in-flight request and empties the skid buffer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            skid_valid <= 1'b0;
            skid       <= '0;
            zero_q     <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            skid_valid <= skid_valid_next;
            skid       <= skid_next;
            zero_q     <= zero_next;
            overflow_q <= overflow_next;
        end
    end

    dmem_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clock(clock),
        .re   (launch),
        .we   (ram_we),
        .addr (ram_idx),
        .wdata(launch_req.wdata),
        .rdata(ram_rdata)
    );

    assign mem_ready = (state == RESP);
    assign mem_rdata = (state == RESP && !zero_q) ? ram_rdata : 32'h0;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder at latencies 1, 3 and 4.
module tb_dmem_responder;

    typedef struct packed {
        logic        valid;
        logic        fence;
        logic        spec;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_tb = 1'b0;
    bus_t        bus   [3];
    logic        ready [3];
    logic [31:0] rdata [3];
    logic        ovf   [3];

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    // Free-running clock and cycle counter.
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_LOG2(12), .LATENCY(1), .BASE_ADDR(32'h0)) u1 (
        .clock(clock), .reset(reset),
        .mem_valid(bus[0].valid), .mem_fence(bus[0].fence), .mem_spec(bus[0].spec),
        .mem_instr(instr_tb), .mem_addr(bus[0].addr), .mem_wdata(bus[0].wdata),
        .mem_wstrb(bus[0].wstrb), .mem_ready(ready[0]), .mem_rdata(rdata[0]),
        .overflow(ovf[0]));

    dmem_responder #(.DEPTH_LOG2(12), .LATENCY(3), .BASE_ADDR(32'h0)) u3 (
        .clock(clock), .reset(reset),
        .mem_valid(bus[1].valid), .mem_fence(bus[1].fence), .mem_spec(bus[1].spec),
        .mem_instr(instr_tb), .mem_addr(bus[1].addr), .mem_wdata(bus[1].wdata),
        .mem_wstrb(bus[1].wstrb), .mem_ready(ready[1]), .mem_rdata(rdata[1]),
        .overflow(ovf[1]));

    dmem_responder #(.DEPTH_LOG2(12), .LATENCY(4), .BASE_ADDR(32'h0)) u4 (
        .clock(clock), .reset(reset),
        .mem_valid(bus[2].valid), .mem_fence(bus[2].fence), .mem_spec(bus[2].spec),
        .mem_instr(instr_tb), .mem_addr(bus[2].addr), .mem_wdata(bus[2].wdata),
        .mem_wstrb(bus[2].wstrb), .mem_ready(ready[2]), .mem_rdata(rdata[2]),
        .overflow(ovf[2]));

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Drive one request pulse for a cycle and queue its expected response.
    task automatic applyStimulus(input int inst, input logic fence, input logic spec,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, input bit expect_resp,
                                 input int delay, input logic [31:0] exp_data);
        exp_t e;
        e.cyc  = cyc + delay;
        e.data = exp_data;
        if (expect_resp) begin
            case (inst)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
        bus[inst] = {1'b1, fence, spec, addr, wdata, wstrb};
        @(posedge clock);
        #1;
        bus[inst] = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic popExpected(input int inst, output bit got, output exp_t e);
        got = 1'b0;
        e.cyc = 0;
        e.data = 32'h0;
        case (inst)
            0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
        endcase
    endtask

    // Monitor: every response is matched in order against the scoreboard.
    always @(negedge clock) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) begin
                bit   got;
                exp_t e;
                if (ready[i]) begin
                    popExpected(i, got, e);
                    if (!got) begin
                        checkOutput($sformatf("u%0d_unexpected_ready", i), {31'b0, ready[i]}, 32'h0);
                    end else begin
                        checkOutput($sformatf("u%0d_resp_cycle", i), 32'(cyc), 32'(e.cyc));
                        checkOutput($sformatf("u%0d_resp_data", i), rdata[i], e.data);
                    end
                end else begin
                    checkOutput($sformatf("u%0d_rdata_idle", i), rdata[i], 32'h0);
                end
            end
        end
    end

    // Watchdog bound on the whole run.
    always @(posedge clock) begin
        if (cyc > 3000) begin
            $display("[TB] FAIL watchdog actual=%0d required<=3000 cycles", cyc);
            $fatal(1, "[TB] watchdog expired");
        end
    end

    initial begin
        int c0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) bus[i] = '0;
        repeat (3) @(posedge clock);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;

        $display("[TB] reset state");
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("u%0d_reset_ready", i), {31'b0, ready[i]}, 32'h0);
            checkOutput($sformatf("u%0d_reset_rdata", i), rdata[i], 32'h0);
            checkOutput($sformatf("u%0d_reset_overflow", i), {31'b0, ovf[i]}, 32'h0);
        end
        idle(1);

        $display("[TB] latency 1: write/read, lanes, range, spec, fence");
        applyStimulus(0, 0, 0, 32'h100,   32'hDEADBEEF, 4'hF, 1, 1, 32'h0);
        applyStimulus(0, 0, 0, 32'h100,   32'h0,        4'h0, 1, 1, 32'hDEADBEEF);
        applyStimulus(0, 0, 0, 32'h104,   32'h11223344, 4'hF, 1, 1, 32'h0);
        applyStimulus(0, 0, 0, 32'h104,   32'h000000AA, 4'h1, 1, 1, 32'h0);
        applyStimulus(0, 0, 0, 32'h104,   32'h0,        4'h0, 1, 1, 32'h112233AA);
        applyStimulus(0, 0, 0, 32'h104,   32'h55660000, 4'hC, 1, 1, 32'h0);
        applyStimulus(0, 0, 0, 32'h104,   32'h0,        4'h0, 1, 1, 32'h556633AA);
        idle(2);
        applyStimulus(0, 0, 0, 32'h10000, 32'h0,        4'h0, 1, 1, 32'h0);
        applyStimulus(0, 0, 0, 32'h10100, 32'h12345678, 4'hF, 1, 1, 32'h0);
        applyStimulus(0, 0, 0, 32'h100,   32'h0,        4'h0, 1, 1, 32'hDEADBEEF);
        applyStimulus(0, 0, 0, 32'h200,   32'h0BADF00D, 4'hF, 1, 1, 32'h0);
        applyStimulus(0, 0, 1, 32'h200,   32'hFFFFFFFF, 4'hF, 1, 1, 32'h0);
        applyStimulus(0, 0, 0, 32'h200,   32'h0,        4'h0, 1, 1, 32'h0BADF00D);
        idle(1);
        applyStimulus(0, 1, 0, 32'h100,   32'h0,        4'hF, 1, 1, 32'h0);
        applyStimulus(0, 0, 0, 32'h103,   32'h0,        4'h0, 1, 1, 32'hDEADBEEF);
        idle(3);

        $display("[TB] latency 3: skid and overflow");
        applyStimulus(1, 0, 0, 32'h100, 32'hA1A1A1A1, 4'hF, 1, 3, 32'h0);
        idle(3);
        applyStimulus(1, 0, 0, 32'h104, 32'hB2B2B2B2, 4'hF, 1, 3, 32'h0);
        idle(3);
        applyStimulus(1, 0, 0, 32'h108, 32'hC3C3C3C3, 4'hF, 1, 3, 32'h0);
        idle(3);
        c0 = cyc;
        applyStimulus(1, 0, 0, 32'h100, 32'h0, 4'h0, 1, 3, 32'hA1A1A1A1);
        applyStimulus(1, 0, 0, 32'h104, 32'h0, 4'h0, 1, 5, 32'hB2B2B2B2);
        checkOutput("u3_overflow_before_drop", {31'b0, ovf[1]}, 32'h0);
        applyStimulus(1, 0, 0, 32'h108, 32'h0, 4'h0, 0, 0, 32'h0);
        checkOutput("u3_overflow_cycle", 32'(cyc - c0), 32'd3);
        checkOutput("u3_overflow_set", {31'b0, ovf[1]}, 32'h1);
        idle(6);
        checkOutput("u3_overflow_sticky", {31'b0, ovf[1]}, 32'h1);
        applyStimulus(1, 1, 0, 32'h108, 32'h0, 4'hF, 1, 3, 32'h0);
        idle(3);
        applyStimulus(1, 0, 0, 32'h108, 32'h0, 4'h0, 1, 3, 32'hC3C3C3C3);
        idle(4);

        $display("[TB] latency 4: reset mid-operation");
        applyStimulus(2, 0, 0, 32'h300, 32'h77777777, 4'hF, 0, 0, 32'h0);
        idle(1);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        idle(6);
        checkOutput("u4_overflow_after_reset", {31'b0, ovf[2]}, 32'h0);
        checkOutput("u3_overflow_after_reset", {31'b0, ovf[1]}, 32'h0);
        applyStimulus(2, 0, 0, 32'h300, 32'h0, 4'h0, 1, 4, 32'h77777777);
        idle(6);

        checkOutput("u1_queue_empty", 32'(q0.size()), 32'h0);
        checkOutput("u3_queue_empty", 32'(q1.size()), 32'h0);
        checkOutput("u4_queue_empty", 32'(q2.size()), 32'h0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
